panel_scan_sequencer: RTL and testbench
=======================================

PANEL_SCAN_SEQUENCER -- requirements
Module: panel_scan_sequencer

Interface
REQ-001 Parameter ROWS, default 8: number of panel rows scanned per frame (>=2).
REQ-002 Parameter COLS, default 32: shift pulses per row (>=2).
REQ-003 Parameter DISP_TICKS, default 4: ticks each row is displayed (>=1).
REQ-004 Parameter DIV_W, default 16: width of the tick-period register.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  high = run scanning; low = stop at end of current row.
REQ-008 period_load  input  1  single-cycle strobe that loads period_in.
REQ-009 period_in  input  DIV_W  tick period in clk cycles; 0 is treated as 1.
REQ-010 shift_clk  output  1  one-clk-wide column shift pulse.
REQ-011 col_idx  output  $clog2(COLS)  index of the column being shifted.
REQ-012 row  output  $clog2(ROWS)  currently selected row.
REQ-013 blank  output  1  high = panel output disabled.
REQ-014 latch  output  1  one-clk-wide row latch pulse.
REQ-015 frame_done  output  1  one-clk pulse after the last row's display phase ends.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The internal tick counter SHALL count 0..P-1, where P is the held period, and assert tick for one clk when count==P-1; P=1 gives tick every cycle.
REQ-018 A period_load SHALL update P on the next edge and clear the tick counter, so the first new tick comes P cycles after the load.
REQ-019 The FSM states SHALL be IDLE, SHIFT, BLANK, LATCH and DISPLAY, and transitions SHALL occur only on tick, except for the IDLE exit.
REQ-020 In IDLE with enable=1, the FSM SHALL enter SHIFT on the next edge with col_idx=0 and the tick counter cleared.
REQ-021 In SHIFT, each tick SHALL produce shift_clk=1 for that clk cycle and then increment col_idx.
REQ-022 On the tick where col_idx==COLS-1, the FSM SHALL go to BLANK and col_idx SHALL wrap to 0.
REQ-023 In BLANK, blank SHALL be 1; the next tick SHALL move the FSM to LATCH.
REQ-024 In LATCH, latch SHALL pulse on the tick and row SHALL advance on the same edge (ROWS-1 wraps to 0, except on the first row after IDLE, which keeps row=0); the FSM then goes to DISPLAY.
REQ-025 In DISPLAY, blank SHALL be 0 for exactly DISP_TICKS ticks.
REQ-026 On the last DISPLAY tick: if row==ROWS-1, frame_done SHALL pulse.
REQ-027 On the last DISPLAY tick, the FSM SHALL go to SHIFT if enable=1, else to IDLE.
REQ-028 blank SHALL be 1 in IDLE, SHIFT, BLANK and LATCH.
REQ-029 When enable is deasserted mid-row, the current row SHALL complete; enable is sampled only at DISPLAY end.
REQ-030 When period_load coincides with a tick, the tick SHALL still take effect and the counter SHALL restart under the new P.

Reset
REQ-031 When reset=1, the next edge SHALL force the FSM to IDLE, P=1, tick counter=0, col_idx=0, row=0, blank=1, and shift_clk=latch=frame_done=busy=0, regardless of state.
REQ-032 reset SHALL take priority over period_load and enable.

Verification
REQ-033 Reset, P=1, enable=1 -> 32 shift_clk pulses on consecutive cycles, then 1 blank tick, then a latch pulse with row=0, then 4 cycles with blank=0.
REQ-034 period_in=5 loaded, then enable -> shift_clk pulses exactly 5 clk apart; col_idx runs 0..31 and wraps to 0.
REQ-035 Run 8 rows at P=1 -> row sequence 0..7; frame_done is a single pulse at the end of row 7's DISPLAY; row then wraps to 0.
REQ-036 Drop enable during SHIFT of row 3 -> row 3 completes its DISPLAY; FSM goes to IDLE with busy=0 and blank=1.
REQ-037 Assert reset during DISPLAY of row 5 -> next cycle all outputs are at reset values and P=1.
REQ-038 Load period_in=0 -> tick behaves as P=1.

Source files
------------

// File: rtl/panel_scan_sequencer.sv
// LED panel row scanner: shifts COLS column pulses, blanks, latches and displays
// each row in turn, all paced by a programmable tick divider.
module panel_scan_sequencer #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 32,
    parameter int unsigned DISP_TICKS = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      period_load,
    input  logic [DIV_W-1:0]          period_in,
    output logic                      shift_clk,
    output logic [$clog2(COLS)-1:0]   col_idx,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic                      blank,
    output logic                      latch,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned DW = $clog2(DISP_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] tcnt_q;
    logic             tick;
    logic             tcnt_clr;
    logic [CW-1:0]    col_n;
    logic [RW-1:0]    row_n;
    logic [DW-1:0]    disp_q, disp_n;
    logic             first_q, first_n;

    assign tick = (tcnt_q == period_q - DIV_W'(1));

    // Tick divider; a load or an IDLE exit restarts the count from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= DIV_W'(1);
            tcnt_q   <= '0;
        end else begin
            if (period_load)
                period_q <= (period_in == '0) ? DIV_W'(1) : period_in;
            if (period_load || tcnt_clr || tick)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_idx <= '0;
            row     <= '0;
            disp_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_n;
            col_idx <= col_n;
            row     <= row_n;
            disp_q  <= disp_n;
            first_q <= first_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        col_n      = col_idx;
        row_n      = row;
        disp_n     = disp_q;
        first_n    = first_q;
        tcnt_clr   = 1'b0;
        shift_clk  = 1'b0;
        latch      = 1'b0;
        frame_done = 1'b0;
        blank      = 1'b1;
        busy       = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    state_n  = SHIFT;
                    col_n    = '0;
                    first_n  = 1'b1;
                    tcnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shift_clk = 1'b1;
                    if (col_idx == CW'(COLS - 1)) begin
                        col_n   = '0;
                        state_n = BLANK;
                    end else begin
                        col_n = col_idx + CW'(1);
                    end
                end
            end
            BLANK: begin
                if (tick)
                    state_n = LATCH;
            end
            LATCH: begin
                if (tick) begin
                    latch   = 1'b1;
                    first_n = 1'b0;
                    disp_n  = '0;
                    state_n = DISPLAY;
                    // The first row after a start always shows row 0.
                    if (first_q || row == RW'(ROWS - 1))
                        row_n = '0;
                    else
                        row_n = row + RW'(1);
                end
            end
            DISPLAY: begin
                blank = 1'b0;
                if (tick) begin
                    if (disp_q == DW'(DISP_TICKS - 1)) begin
                        disp_n     = '0;
                        frame_done = (row == RW'(ROWS - 1));
                        state_n    = enable ? SHIFT : IDLE;
                    end else begin
                        disp_n = disp_q + DW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_panel_scan_sequencer.sv
// Bench for panel_scan_sequencer: per-cycle output traces built from the row
// timing rules (shift/blank/latch/display phase lengths) and compared each cycle.
module tb_panel_scan_sequencer;

    localparam int ROWS       = 8;
    localparam int COLS       = 32;
    localparam int DISP_TICKS = 4;
    localparam int DIV_W      = 16;
    localparam int CW         = $clog2(COLS);
    localparam int RW         = $clog2(ROWS);

    typedef struct packed {
        logic          sc;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          blank;
        logic          latch;
        logic          fd;
        logic          busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             period_load = 1'b0;
    logic [DIV_W-1:0] period_in = '0;
    logic             shift_clk;
    logic [CW-1:0]    col_idx;
    logic [RW-1:0]    row;
    logic             blank, latch, frame_done, busy;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    panel_scan_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DISP_TICKS(DISP_TICKS), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .period_load(period_load),
        .period_in(period_in), .shift_clk(shift_clk), .col_idx(col_idx), .row(row),
        .blank(blank), .latch(latch), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t observe();
        exp_t o;
        o.sc = shift_clk; o.col = col_idx; o.row = row; o.blank = blank;
        o.latch = latch; o.fd = frame_done; o.busy = busy;
        return o;
    endfunction

    function automatic exp_t mk(input bit sc, input int col, input int r, input bit bl,
                                input bit la, input bit fd, input bit bz);
        exp_t e;
        e.sc = sc; e.col = CW'(col); e.row = RW'(r); e.blank = bl;
        e.latch = la; e.fd = fd; e.busy = bz;
        return e;
    endfunction

    // One row of scanning at tick period p: COLS shift ticks, one blank tick,
    // one latch tick, DISP_TICKS display ticks; pulses land on the last cycle of a tick.
    task automatic push_row(input int p, input int rprev, input int rnew);
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < p; k++)
                exp_q.push_back(mk(k == p - 1, c, rprev, 1, 0, 0, 1));
        for (int k = 0; k < p; k++)
            exp_q.push_back(mk(0, 0, rprev, 1, 0, 0, 1));
        for (int k = 0; k < p; k++)
            exp_q.push_back(mk(0, 0, rprev, 1, k == p - 1, 0, 1));
        for (int k = 0; k < DISP_TICKS * p; k++)
            exp_q.push_back(mk(0, 0, rnew, 0, 0,
                               (k == DISP_TICKS * p - 1) && (rnew == ROWS - 1), 1));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; period_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o, e;
        reset = 1'b1; enable = 1'b1; period_load = 1'b1; period_in = 16'd7;
        @(negedge clk);
        @(negedge clk);
        o = observe(); e = mk(0, 0, 0, 1, 0, 0, 0); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_values: got %b want %b", o, e);
        end
        reset = 1'b0; enable = 1'b0; period_load = 1'b0;
        @(negedge clk);
        o = observe(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_idle_hold: got %b want %b", o, e);
        end
        // Load during reset must be ignored: P stays 1, so pulses every cycle.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe(); e = mk(1, i, 0, 1, 0, 0, 1); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_priority_p1 col %0d: got %b want %b", i, o, e);
            end
        end
    endtask

    // Start from reset, optionally load a period, run nrows rows and drop enable
    // drop_off cycles into the last row; then expect IDLE.
    task automatic run_scenario(input string name, input bit do_load, input int pval,
                                input int nrows, input int drop_off);
        int peff, rprev, rr, start_last, drop_idx;
        exp_t o;
        apply_reset();
        if (do_load) begin
            period_in = DIV_W'(pval); period_load = 1'b1;
            @(negedge clk);
            period_load = 1'b0;
        end
        peff = (do_load && pval != 0) ? pval : 1;
        exp_q.delete();
        rprev = 0;
        start_last = 0;
        for (int r = 0; r < nrows; r++) begin
            rr = r % ROWS;
            if (r == nrows - 1) start_last = exp_q.size();
            push_row(peff, rprev, rr);
            rprev = rr;
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(0, 0, rprev, 1, 0, 0, 0));
        drop_idx = start_last + drop_off;
        enable = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            o = observe(); vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got sc=%0b col=%0d row=%0d blank=%0b latch=%0b fd=%0b busy=%0b want sc=%0b col=%0d row=%0d blank=%0b latch=%0b fd=%0b busy=%0b",
                         name, i, o.sc, o.col, o.row, o.blank, o.latch, o.fd, o.busy,
                         exp_q[i].sc, exp_q[i].col, exp_q[i].row, exp_q[i].blank,
                         exp_q[i].latch, exp_q[i].fd, exp_q[i].busy);
            end
            if (i == drop_idx) enable = 1'b0;
        end
        enable = 1'b0;
    endtask

    task automatic test_load_on_tick();
        exp_t o, e;
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            o = observe(); e = mk(1, i, 0, 1, 0, 0, 1); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_tick_pre col %0d: got %b want %b", i, o, e);
            end
        end
        // Load lands on a tick: column still advances, then P=3 pacing.
        period_in = 16'd3; period_load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            period_load = 1'b0;
            e = (k < 3) ? mk(k == 2, 11, 0, 1, 0, 0, 1) : mk(0, 12, 0, 1, 0, 0, 1);
            o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_tick_post %0d: got %b want %b", k, o, e);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_display();
        exp_t o, e;
        apply_reset();
        period_in = 16'd2; period_load = 1'b1;
        @(negedge clk);
        period_load = 1'b0;
        enable = 1'b1;
        // Row 5 display spans cycles 448..455 at P=2.
        for (int i = 0; i <= 450; i++) @(negedge clk);
        vectors++;
        if (row !== RW'(5) || blank !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_display_pre: got row=%0d blank=%0b busy=%0b want row=5 blank=0 busy=1",
                     row, blank, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        o = observe(); e = mk(0, 0, 0, 1, 0, 0, 0); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mid_display_reset: got %b want %b", o, e);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe(); e = mk(1, i, 0, 1, 0, 0, 1); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_display_p1 col %0d: got %b want %b", i, o, e);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        int p, n, d, pe;
        for (int it = 0; it < 5; it++) begin
            p  = $urandom_range(0, 4);
            n  = $urandom_range(1, 10);
            pe = (p == 0) ? 1 : p;
            d  = $urandom_range(0, COLS * pe - 1);
            run_scenario($sformatf("random%0d_p%0d_n%0d", it, p, n), 1'b1, p, n, d);
        end
    endtask

    initial begin
        test_reset();
        run_scenario("basic_row_p1", 1'b0, 1, 1, 5);
        run_scenario("period5", 1'b1, 5, 2, 40);
        run_scenario("full_frame", 1'b0, 1, 9, 3);
        run_scenario("stop_row3", 1'b1, 2, 4, 17);
        run_scenario("period0", 1'b1, 0, 2, 0);
        test_load_on_tick();
        test_reset_mid_display();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
